// File: rtl/uart_receiver_if.sv
// RX-FIFO side of the UART receiver: byte/write strobe, FIFO full, error pulses, busy.
interface uart_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 fifo_wr_en;
   logic                 full;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun_err;
   logic                 busy;

   modport master (
      output data_out, fifo_wr_en, frame_err, parity_err, overrun_err, busy,
      input  full
   );

   modport slave (
      input  data_out, fifo_wr_en, frame_err, parity_err, overrun_err, busy,
      output full
   );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation, LSB-first data, optional parity,
// stop-bit check, and a one-cycle write strobe into the RX FIFO.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rxd,
   uart_receiver_if.master rx
);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS + 1);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic          ODD       = (PARITY_ODD != 0);
   localparam logic          PEN       = (PARITY_EN != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t               state, state_nx;
   logic                 sync1, rx_s;
   logic [CW-1:0]        clk_cnt, clk_nx;
   logic [BW-1:0]        bit_cnt, bit_nx;
   logic [DATA_BITS-1:0] shift, shift_nx;
   logic [DATA_BITS-1:0] data_q, data_nx;
   logic                 pbad, pbad_nx;
   logic                 wr_q, wr_nx;
   logic                 fe_q, fe_nx;
   logic                 pe_q, pe_nx;
   logic                 oe_q, oe_nx;
   logic                 mid;

   // rxd is asynchronous; nothing downstream looks at it before the second flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rxd;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_q  <= '0;
         pbad    <= 1'b0;
         wr_q    <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         clk_cnt <= clk_nx;
         bit_cnt <= bit_nx;
         shift   <= shift_nx;
         data_q  <= data_nx;
         pbad    <= pbad_nx;
         wr_q    <= wr_nx;
         fe_q    <= fe_nx;
         pe_q    <= pe_nx;
         oe_q    <= oe_nx;
      end
   end

   assign mid = (clk_cnt == BIT_LAST);

   always_comb begin
      state_nx = state;
      clk_nx   = clk_cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      data_nx  = data_q;
      pbad_nx  = pbad;
      wr_nx    = 1'b0;
      fe_nx    = 1'b0;
      pe_nx    = 1'b0;
      oe_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx = START;
               clk_nx   = '0;
            end
         end
         START: begin
            // half a bit in: a line that is high again was only a glitch
            if (clk_cnt == HALF_LAST) begin
               clk_nx = '0;
               if (rx_s) begin
                  state_nx = IDLE;
               end else begin
                  bit_nx   = '0;
                  pbad_nx  = 1'b0;
                  state_nx = DATA;
               end
            end else begin
               clk_nx = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (mid) begin
               // right shift: the first bit received ends up in bit 0
               shift_nx = {rx_s, shift[DATA_BITS-1:1]};
               clk_nx   = '0;
               bit_nx   = bit_cnt + 1'b1;
               if (bit_cnt == DATA_LAST) state_nx = PEN ? PARITY : STOP;
            end else begin
               clk_nx = clk_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (mid) begin
               pbad_nx  = (rx_s != ((^shift) ^ ODD));
               clk_nx   = '0;
               state_nx = STOP;
            end else begin
               clk_nx = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (mid) begin
               clk_nx = '0;
               if (!rx_s) begin
                  fe_nx    = 1'b1;
                  state_nx = BRK;
               end else if (pbad) begin
                  pe_nx    = 1'b1;
                  state_nx = IDLE;
               end else if (rx.full) begin
                  oe_nx    = 1'b1;
                  state_nx = IDLE;
               end else begin
                  data_nx  = shift;
                  wr_nx    = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               clk_nx = clk_cnt + 1'b1;
            end
         end
         BRK: begin
            // a held-low line must not be decoded as a stream of zero frames
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign rx.data_out    = data_q;
   assign rx.fifo_wr_en  = wr_q;
   assign rx.frame_err   = fe_q;
   assign rx.parity_err  = pe_q;
   assign rx.overrun_err = oe_q;
   assign rx.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver: default build and an odd-parity build.
module tb_uart_receiver;
   localparam int CPB = 16;
   localparam int K_WR = 1, K_FE = 2, K_PE = 3, K_OE = 4;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rxd0 = 1'b1;
   logic rxd1 = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   multi = 0;
   int   busy_cnt = 0;
   int   s0, s1;
   ev_t  ev0[$];
   ev_t  ev1[$];

   uart_receiver_if #(.DATA_BITS(8)) bus0 ();
   uart_receiver_if #(.DATA_BITS(8)) bus1 ();

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd0), .rx(bus0.master));
   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd1), .rx(bus1.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // observe both DUTs on the falling edge and log every strobe/pulse with its cycle
   always @(negedge clk) begin
      s0 = int'(bus0.fifo_wr_en) + int'(bus0.frame_err) + int'(bus0.parity_err) + int'(bus0.overrun_err);
      s1 = int'(bus1.fifo_wr_en) + int'(bus1.frame_err) + int'(bus1.parity_err) + int'(bus1.overrun_err);
      if (s0 > 1 || s1 > 1) multi = multi + 1;
      if (bus0.busy) busy_cnt = busy_cnt + 1;
      if (bus0.fifo_wr_en)  ev0.push_back('{kind: K_WR, data: bus0.data_out, cyc: cyc});
      if (bus0.frame_err)   ev0.push_back('{kind: K_FE, data: bus0.data_out, cyc: cyc});
      if (bus0.parity_err)  ev0.push_back('{kind: K_PE, data: bus0.data_out, cyc: cyc});
      if (bus0.overrun_err) ev0.push_back('{kind: K_OE, data: bus0.data_out, cyc: cyc});
      if (bus1.fifo_wr_en)  ev1.push_back('{kind: K_WR, data: bus1.data_out, cyc: cyc});
      if (bus1.frame_err)   ev1.push_back('{kind: K_FE, data: bus1.data_out, cyc: cyc});
      if (bus1.parity_err)  ev1.push_back('{kind: K_PE, data: bus1.data_out, cyc: cyc});
      if (bus1.overrun_err) ev1.push_back('{kind: K_OE, data: bus1.data_out, cyc: cyc});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: outcome of a frame from its bits alone, by the documented priority
   function automatic int exp_kind(input logic [7:0] d, input bit pen, input logic pbit,
                                   input logic stop, input logic f);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      if (!stop) return K_FE;
      if (pen && (((ones + int'(pbit)) % 2) != 1)) return K_PE;
      if (f) return K_OE;
      return K_WR;
   endfunction

   function automatic int exp_lat(input bit pen);
      return 2 + CPB / 2 + (8 + int'(pen) + 1) * CPB + 1;
   endfunction

   task automatic set_line(input int w, input logic b);
      if (w == 0) rxd0 = b; else rxd1 = b;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // leaves the line at the stop level so back-to-back frames need no gap
   task automatic send_frame(input int w, input logic [7:0] d, input logic pbit,
                             input logic stop, input int stop_bits, output int t_fall);
      set_line(w, 1'b0);
      t_fall = cyc;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         set_line(w, d[i]);
         idle(CPB);
      end
      if (w == 1) begin
         set_line(w, pbit);
         idle(CPB);
      end
      set_line(w, stop);
      idle(CPB * stop_bits);
   endtask

   task automatic check_frame(input int w, input string tag, input int kind,
                              input logic [7:0] d, input int tf, input int lat);
      ev_t e;
      int  sz;
      sz = (w == 0) ? ev0.size() : ev1.size();
      chk($sformatf("%s.count", tag), sz, 1);
      if (sz > 0) begin
         if (w == 0) e = ev0.pop_front(); else e = ev1.pop_front();
         chk($sformatf("%s.kind", tag), e.kind, kind);
         chk($sformatf("%s.latency", tag), e.cyc - tf, lat);
         if (kind == K_WR) chk($sformatf("%s.data", tag), e.data, d);
      end
      if (w == 0) ev0.delete(); else ev1.delete();
   endtask

   initial begin
      int         tf, tf2, k, c1;
      logic [7:0] d, last0, last1;
      logic       stop, f, pb;
      ev_t        e;
      bus0.full = 1'b0;
      bus1.full = 1'b0;
      last0 = 8'h00;
      last1 = 8'h00;

      // reset state
      #12;
      chk("rst.data_out", bus0.data_out, 0);
      chk("rst.wr_en", bus0.fifo_wr_en, 0);
      chk("rst.busy", bus0.busy, 0);
      chk("rst.errs", {bus0.frame_err, bus0.parity_err, bus0.overrun_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // 0xA5, nominal latency
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1, tf);
      check_frame(0, "a5", K_WR, 8'hA5, tf, exp_lat(0));
      last0 = 8'hA5;
      idle(10);
      chk("a5.held", bus0.data_out, last0);

      // short glitch
      busy_cnt = 0;
      set_line(0, 1'b0);
      idle(4);
      set_line(0, 1'b1);
      idle(30);
      chk("glitch.busy_max", (busy_cnt <= CPB / 2 + 2), 1);
      chk("glitch.busy_seen", (busy_cnt > 0), 1);
      chk("glitch.events", ev0.size(), 0);

      // framing error then a held-low line
      send_frame(0, 8'h3C, 1'b0, 1'b0, 40, tf);
      check_frame(0, "brk", K_FE, 8'h3C, tf, exp_lat(0));
      chk("brk.busy_low", bus0.busy, 1);
      set_line(0, 1'b1);
      idle(20);
      chk("brk.busy_rel", bus0.busy, 0);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 1, tf);
      check_frame(0, "brk.next", K_WR, 8'h3C, tf, exp_lat(0));
      last0 = 8'h3C;

      // overrun
      bus0.full = 1'b1;
      send_frame(0, 8'h77, 1'b0, 1'b1, 1, tf);
      bus0.full = 1'b0;
      check_frame(0, "ovr", K_OE, 8'h77, tf, exp_lat(0));
      chk("ovr.held", bus0.data_out, last0);

      // odd parity
      send_frame(1, 8'h01, 1'b1, 1'b1, 1, tf);
      check_frame(1, "par.bad", K_PE, 8'h01, tf, exp_lat(1));
      send_frame(1, 8'h01, 1'b0, 1'b1, 1, tf);
      check_frame(1, "par.good", K_WR, 8'h01, tf, exp_lat(1));
      last1 = 8'h01;
      chk("par.data_out", bus1.data_out, last1);

      // back-to-back, zero idle gap
      send_frame(0, 8'h00, 1'b0, 1'b1, 1, tf);
      send_frame(0, 8'hFF, 1'b0, 1'b1, 1, tf2);
      chk("b2b.count", ev0.size(), 2);
      if (ev0.size() == 2) begin
         e = ev0.pop_front();
         c1 = e.cyc;
         chk("b2b.first", e.data, 8'h00);
         chk("b2b.lat", e.cyc - tf, exp_lat(0));
         e = ev0.pop_front();
         chk("b2b.second", e.data, 8'hFF);
         chk("b2b.spacing", e.cyc - c1, 10 * CPB);
      end
      ev0.delete();
      last0 = 8'hFF;

      // reset in the middle of the data bits
      set_line(0, 1'b0);
      idle(CPB);
      for (int i = 0; i < 3; i++) begin
         set_line(0, d[0] ^ d[0] ^ ((8'h5A >> i) & 1));
         idle(CPB);
      end
      chk("mid.busy", bus0.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid.data_out", bus0.data_out, 0);
      chk("mid.busy_rst", bus0.busy, 0);
      chk("mid.wr_en", bus0.fifo_wr_en, 0);
      @(negedge clk);
      set_line(0, 1'b1);
      set_line(1, 1'b1);
      idle(5);
      rst_n = 1'b1;
      idle(CPB * 12);
      chk("mid.no_events", ev0.size() + ev1.size(), 0);
      last0 = 8'h00;
      last1 = 8'h00;
      send_frame(0, 8'hC3, 1'b0, 1'b1, 1, tf);
      check_frame(0, "mid.next", K_WR, 8'hC3, tf, exp_lat(0));
      last0 = 8'hC3;

      // random frames against the reference outcome
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 3) == 0);
         bus0.full = f;
         send_frame(0, d, 1'b0, stop, 1, tf);
         k = exp_kind(d, 1'b0, 1'b0, stop, f);
         if (k == K_WR) last0 = d;
         check_frame(0, $sformatf("rnd0[%0d]", i), k, d, tf, exp_lat(0));
         bus0.full = 1'b0;
         set_line(0, 1'b1);
         idle(4);
         chk($sformatf("rnd0[%0d].data_out", i), bus0.data_out, last0);
      end
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         pb = 1'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         f = ($urandom_range(0, 4) == 0);
         bus1.full = f;
         send_frame(1, d, pb, stop, 1, tf);
         k = exp_kind(d, 1'b1, pb, stop, f);
         if (k == K_WR) last1 = d;
         check_frame(1, $sformatf("rnd1[%0d]", i), k, d, tf, exp_lat(1));
         bus1.full = 1'b0;
         set_line(1, 1'b1);
         idle(4);
         chk($sformatf("rnd1[%0d].data_out", i), bus1.data_out, last1);
      end

      chk("exclusive", multi, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage that sits directly downstream of the transmitter's txd line.
- Oversamples rxd, validates the start bit, and shifts in DATA_BITS LSB-first.
- Optionally checks parity, then checks the stop bit.
- Writes each good byte into the RX FIFO with a single-cycle write strobe; flags framing, parity and overrun errors.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; minimum 2. Mid-bit sample offset HALF = CLKS_PER_BIT/2 (integer division).
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial input, idle high; asynchronous to clk.
- full  input  1  RX FIFO full.
- data_out  output  DATA_BITS  received byte; valid while fifo_wr_en=1; held until the next write.
- fifo_wr_en  output  1  one-cycle write strobe to the RX FIFO.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- overrun_err  output  1  one-cycle pulse: good frame dropped because full=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low. On reset:
  - data_out=0, fifo_wr_en=0, all error pulses=0, busy=0.
  - Both synchronizer flops=1.
  - State=IDLE, bit counter=0, clock counter=0.
  - Reset mid-frame abandons the frame with no write and no error.
- Input path: 2-flop synchronizer on rxd feeds rx_s; all decisions use rx_s only.
- IDLE:
  - rx_s=0 -> START with clk_cnt=0.
- START:
  - clk_cnt counts up each cycle.
  - At clk_cnt=HALF-1: if rx_s=1, treat as a glitch and go to IDLE with no flags. Otherwise clk_cnt=0, bit_cnt=0, go to DATA.
- DATA:
  - At clk_cnt=CLKS_PER_BIT-1 (the mid-bit point), sample rx_s into shift bit bit_cnt (LSB first), clear clk_cnt, increment bit_cnt.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample one bit at the mid-bit point.
  - Expected value = XOR of the data bits, inverted when PARITY_ODD.
  - Latch the mismatch internally, then go to STOP.
- STOP: sample at the mid-bit point. Priority:
  1. rx_s=0 -> frame_err pulse; no write; go to BREAK.
  2. Parity mismatch -> parity_err pulse; no write; go to IDLE.
  3. full=1 -> overrun_err pulse; byte dropped; data_out unchanged; go to IDLE.
  4. Otherwise data_out<=shift register, fifo_wr_en=1 for exactly one cycle, go to IDLE.
- BREAK:
  - Wait until rx_s=1, then go to IDLE. A line held low never produces repeated frames.
- Output timing: outputs are registered. Pulses and fifo_wr_en assert in the cycle after the stop-bit sample edge.
- Latency, rxd falling edge to fifo_wr_en: 2 (sync) + HALF + (DATA_BITS + PARITY_EN + 1) x CLKS_PER_BIT + 1 cycles. For defaults, 2+8+144+1 = 155 cycles.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint. A start edge arriving right after the stop bit is detected with no lost frame.
- Counters: clk_cnt width is clog2(CLKS_PER_BIT); bit_cnt width is clog2(DATA_BITS+1). No counter wraps outside its state.
- Exclusivity: only one of fifo_wr_en, frame_err, parity_err, overrun_err is high in any cycle.

Test Plan:
- Defaults, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit -> one fifo_wr_en pulse 155 cycles after the falling edge; data_out=0xA5; no errors.
- rxd low for 4 cycles, then high -> state returns to IDLE; no fifo_wr_en, no error; busy high for at most HALF+2 cycles.
- Frame 0x3C with stop bit 0, rxd held low 40 bits, then high -> one frame_err pulse, no fifo_wr_en, no further activity until rxd=1; next frame 0x3C is received correctly.
- full=1 during the stop bit of 0x77 -> overrun_err pulse, no fifo_wr_en, data_out keeps its previous value.
- PARITY_EN=1, PARITY_ODD=1: send 0x01 with parity bit 1 -> parity_err, no write. Send 0x01 with parity bit 0 -> write of 0x01.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two fifo_wr_en pulses, 160 cycles apart, data 0x00 then 0xFF.
- Assert rst_n=0 mid-DATA of 0x5A -> all outputs 0 immediately; the following frame 0xC3 is received correctly.
